// File: rtl/fifo_rr_drain.sv
// Round-robin drain of N_CH source FIFOs (1-cycle read latency) into a 2-entry
// output buffer with valid/ready handshake and per-word source channel tag.
module fifo_rr_drain #(
    parameter int N_CH      = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_CH-1:0]            fifo_empty,
    output logic [N_CH-1:0]            fifo_rd_en,
    input  logic [N_CH*WIDTH-1:0]      fifo_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [WIDTH-1:0]           m_data,
    output logic [$clog2(N_CH)-1:0]    m_chan
);

    localparam int CW = $clog2(N_CH);
    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t            state_r, state_s;
    logic [CW-1:0]     grant_r, grant_s;
    logic [CW-1:0]     last_grant_r, last_grant_s;
    logic [BW-1:0]     burst_cnt_r, burst_cnt_s, cnt_inc_s;
    logic              inflight_r;
    logic [CW-1:0]     inflight_ch_r;
    logic [1:0]        occ_r, occ_s;
    logic              valid_r;
    logic [WIDTH-1:0]  buf_data_r [2];
    logic [CW-1:0]     buf_chan_r [2];
    logic              pop_s, space_s, rd_s, found_s;
    logic [CW-1:0]     rd_ch_s, pick_s;
    logic [WIDTH-1:0]  cap_data_s;

    assign m_valid    = valid_r;
    assign m_data     = buf_data_r[0];
    assign m_chan     = buf_chan_r[0];
    assign pop_s      = valid_r && m_ready;
    assign cap_data_s = fifo_data[inflight_ch_r*WIDTH +: WIDTH];
    assign cnt_inc_s  = burst_cnt_r + BW'(1);
    // The in-flight read already owns a buffer slot, so it is counted before a new read is allowed.
    assign space_s    = (({1'b0, occ_r} + {2'b00, inflight_r}) - {2'b00, pop_s}) < 3'd2;
    assign occ_s      = (occ_r + {1'b0, inflight_r}) - {1'b0, pop_s};

    // Round-robin search: first non-empty channel starting after last_grant
    always_comb begin
        found_s = 1'b0;
        pick_s  = '0;
        for (int k = 1; k <= N_CH; k++) begin
            int idx;
            idx = (int'(last_grant_r) + k) % N_CH;
            if (!found_s && !fifo_empty[idx]) begin
                found_s = 1'b1;
                pick_s  = CW'(idx);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Arbitration FSM next-state and read issue
    always_comb begin
        state_s      = state_r;
        grant_s      = grant_r;
        last_grant_s = last_grant_r;
        burst_cnt_s  = burst_cnt_r;
        rd_s         = 1'b0;
        rd_ch_s      = grant_r;
        if (reset) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (found_s) begin
                        state_s     = BURST;
                        grant_s     = pick_s;
                        burst_cnt_s = '0;
                        rd_ch_s     = pick_s;
                        if (space_s) begin
                            rd_s        = 1'b1;
                            burst_cnt_s = BW'(1);
                            if (BW'(1) == BW'(MAX_BURST)) begin
                                state_s      = IDLE;
                                last_grant_s = pick_s;
                            end else begin
                                state_s = BURST;
                            end
                        end else begin
                            rd_s = 1'b0;
                        end
                    end else begin
                        state_s = IDLE;
                    end
                end
                BURST: begin
                    if (!fifo_empty[grant_r]) begin
                        if (space_s) begin
                            rd_s        = 1'b1;
                            burst_cnt_s = cnt_inc_s;
                            if (cnt_inc_s == BW'(MAX_BURST)) begin
                                state_s      = IDLE;
                                last_grant_s = grant_r;
                            end else begin
                                state_s = BURST;
                            end
                        end else begin
                            state_s = BURST;
                        end
                    end else begin
                        state_s      = IDLE;
                        last_grant_s = grant_r;
                    end
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
    end

    // One-hot read strobe decode
    always_comb begin
        fifo_rd_en = '0;
        if (rd_s) begin
            fifo_rd_en[rd_ch_s] = 1'b1;
        end else begin
            fifo_rd_en = '0;
        end
    end

    // Arbitration state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            grant_r      <= '0;
            last_grant_r <= CW'(N_CH - 1);
            burst_cnt_r  <= '0;
        end else begin
            state_r      <= state_s;
            grant_r      <= grant_s;
            last_grant_r <= last_grant_s;
            burst_cnt_r  <= burst_cnt_s;
        end
    end

    // Read-latency tracking and 2-entry output buffer; entry 0 is always the oldest
    always_ff @(posedge clk) begin
        if (reset) begin
            inflight_r    <= 1'b0;
            inflight_ch_r <= '0;
            occ_r         <= 2'd0;
            valid_r       <= 1'b0;
            buf_data_r[0] <= '0;
            buf_data_r[1] <= '0;
            buf_chan_r[0] <= '0;
            buf_chan_r[1] <= '0;
        end else begin
            inflight_r    <= rd_s;
            inflight_ch_r <= rd_ch_s;
            occ_r         <= occ_s;
            valid_r       <= (occ_s != 2'd0);
            case ({inflight_r, pop_s})
                2'b01: begin
                    buf_data_r[0] <= buf_data_r[1];
                    buf_chan_r[0] <= buf_chan_r[1];
                end
                2'b10: begin
                    if (occ_r == 2'd0) begin
                        buf_data_r[0] <= cap_data_s;
                        buf_chan_r[0] <= inflight_ch_r;
                    end else begin
                        buf_data_r[1] <= cap_data_s;
                        buf_chan_r[1] <= inflight_ch_r;
                    end
                end
                2'b11: begin
                    if (occ_r == 2'd1) begin
                        buf_data_r[0] <= cap_data_s;
                        buf_chan_r[0] <= inflight_ch_r;
                    end else begin
                        buf_data_r[0] <= buf_data_r[1];
                        buf_chan_r[0] <= buf_chan_r[1];
                        buf_data_r[1] <= cap_data_s;
                        buf_chan_r[1] <= inflight_ch_r;
                    end
                end
                default: begin
                    buf_data_r[0] <= buf_data_r[0];
                end
            endcase
        end
    end

endmodule
